// File: rtl/uart_tx_fifo.sv
`timescale 1ns/100ps
// uart_tx_fifo: FIFO-fed UART transmitter (LSB first, 1-2 stop bits); define UART_TX_PARITY_EN for a parity bit.
// Start bit leaves one edge after a push into an idle empty FIFO; tx_ready = !full, frames run back-to-back.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        bit_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned TW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [TW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bit_out_q, bit_out_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_ready   = (count_q != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign bit_out    = bit_out_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BIT_LAST) begin
          baud_d   = '0;
          bitcnt_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d   = '0;
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bitcnt_q == DATA_LAST) state_d = PARITY;
`else
          if (bitcnt_q == DATA_LAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when a word is waiting.
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = (^mem_q[rd_ptr_q]) ^ 1'(PARITY_ODD);
`endif
    end

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      START:   bit_out_d = 1'b0;
      DATA:    bit_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  bit_out_d = parity_d;
`endif
      default: bit_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      bit_out_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      bit_out_q <= bit_out_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end
endmodule
